smaqa_datapath: RTL and testbench

SMAQA_DATAPATH -- requirements
Module: smaqa_datapath

---
 rtl/ariane_pkg.sv | 13 +
 rtl/smaqa_datapath.sv | 150 +++++++++++++++
 tb/tb_smaqa_datapath.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Functional-unit operation codes shared by the decoder and the multiplier.
package ariane_pkg;

  typedef enum logic [3:0] {
    ADD,
    MUL,
    MULH,
    MULHSU,
    MULHU,
    SMAQA
  } fu_op;

endpackage

// File: rtl/smaqa_datapath.sv
// Decoder, 32-entry register file and single-cycle multiplier for the
// MUL/MULH/MULHSU/MULHU group plus the SMAQA signed 8-bit dot-product
// accumulate.
module smaqa_datapath
  import ariane_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned NR_READ_PORTS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              instruction_i,
  input  logic                     mult_valid_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [4:0]               waddr_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic                     we_i,
  output fu_op                     op_o,
  output logic                     illegal_instr_o,
  output logic [XLEN-1:0]          operand_a_o,
  output logic [XLEN-1:0]          operand_b_o,
  output logic [XLEN-1:0]          operand_c_o,
  output logic [XLEN-1:0]          result_o,
  output logic                     mult_valid_o,
  output logic                     mult_ready_o,
  output logic [TRANS_ID_BITS-1:0] mult_trans_id_o
);

  localparam int unsigned LANES = XLEN / 8;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      raddr [NR_READ_PORTS];
  logic [XLEN-1:0] rdata [NR_READ_PORTS];
  logic [XLEN-1:0] regs_q [32];

  logic                     issue;
  logic                     a_signed, b_signed;
  logic [2*XLEN-1:0]        ext_a, ext_b, prod;
  logic [15:0]              lane_a, lane_b, lane_p;
  logic [XLEN-1:0]          dot;
  logic [XLEN-1:0]          result_d, result_q;
  logic                     valid_q;
  logic [TRANS_ID_BITS-1:0] trans_id_q;

  assign opcode = instruction_i[6:0];
  assign funct3 = instruction_i[14:12];
  assign funct7 = instruction_i[31:25];

  // Decode the instruction word into an operation; unknown encodings fall back to ADD
  always_comb begin
    op_o            = ADD;
    illegal_instr_o = 1'b1;
    if (opcode == 7'h77 && funct7 == 7'h64 && funct3 == 3'd0) begin
      op_o            = SMAQA;
      illegal_instr_o = 1'b0;
    end else if (opcode == 7'h33 && funct7 == 7'h01 && funct3[2] == 1'b0) begin
      illegal_instr_o = 1'b0;
      case (funct3[1:0])
        2'd0:    op_o = MUL;
        2'd1:    op_o = MULH;
        2'd2:    op_o = MULHSU;
        default: op_o = MULHU;
      endcase
    end
  end

  // Read addresses: rs1, rs2 and rd (rd is the SMAQA accumulator source)
  always_comb begin
    for (int p = 0; p < NR_READ_PORTS; p++) raddr[p] = '0;
    raddr[0] = instruction_i[19:15];
    raddr[1] = instruction_i[24:20];
    raddr[2] = instruction_i[11:7];
  end

  // Asynchronous reads; x0 is never written, so it reads back its reset value of 0
  always_comb begin
    for (int p = 0; p < NR_READ_PORTS; p++) rdata[p] = regs_q[raddr[p]];
  end

  assign operand_a_o = rdata[0];
  assign operand_b_o = rdata[1];
  assign operand_c_o = rdata[2];

  // Register-file write port; same-cycle readers see the old value until the edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < 32; r++) regs_q[r] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // One shared 2*XLEN multiplier; operand extension selects the signedness of each side
  always_comb begin
    a_signed = (op_o == MULH) || (op_o == MULHSU);
    b_signed = (op_o == MULH);
    ext_a    = a_signed ? {{XLEN{operand_a_o[XLEN-1]}}, operand_a_o} : {{XLEN{1'b0}}, operand_a_o};
    ext_b    = b_signed ? {{XLEN{operand_b_o[XLEN-1]}}, operand_b_o} : {{XLEN{1'b0}}, operand_b_o};
    prod     = ext_a * ext_b;
  end

  // SMAQA lanes: 16-bit signed byte products sign-extended and accumulated onto rd, wrapping at XLEN
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    lane_p = '0;
    dot    = operand_c_o;
    for (int i = 0; i < LANES; i++) begin
      lane_a = {{8{operand_a_o[8*i+7]}}, operand_a_o[8*i +: 8]};
      lane_b = {{8{operand_b_o[8*i+7]}}, operand_b_o[8*i +: 8]};
      lane_p = lane_a * lane_b;
      dot    = dot + {{(XLEN-16){lane_p[15]}}, lane_p};
    end
  end

  // Result select
  always_comb begin
    case (op_o)
      SMAQA:   result_d = dot;
      MUL:     result_d = prod[XLEN-1:0];
      default: result_d = prod[2*XLEN-1:XLEN];
    endcase
  end

  assign issue        = mult_valid_i && !illegal_instr_o;
  assign mult_ready_o = 1'b1;

  // Output stage: valid follows every edge, result and tag only load on an issue
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      trans_id_q <= '0;
    end else begin
      valid_q <= issue;
      if (issue) begin
        result_q   <= result_d;
        trans_id_q <= trans_id_i;
      end
    end
  end

  assign result_o        = result_q;
  assign mult_valid_o    = valid_q;
  assign mult_trans_id_o = trans_id_q;

endmodule

// File: tb/tb_smaqa_datapath.sv
// Directed bench for smaqa_datapath with a result scoreboard.
module tb_smaqa_datapath;
  import ariane_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction_i;
  logic        mult_valid_i;
  logic [2:0]  trans_id_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        we_i;
  fu_op        op_o;
  logic        illegal_instr_o;
  logic [31:0] operand_a_o, operand_b_o, operand_c_o, result_o;
  logic        mult_valid_o, mult_ready_o;
  logic [2:0]  mult_trans_id_o;

  smaqa_datapath dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .instruction_i  (instruction_i),
    .mult_valid_i   (mult_valid_i),
    .trans_id_i     (trans_id_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .we_i           (we_i),
    .op_o           (op_o),
    .illegal_instr_o(illegal_instr_o),
    .operand_a_o    (operand_a_o),
    .operand_b_o    (operand_b_o),
    .operand_c_o    (operand_c_o),
    .result_o       (result_o),
    .mult_valid_o   (mult_valid_o),
    .mult_ready_o   (mult_ready_o),
    .mult_trans_id_o(mult_trans_id_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] res;
    logic [2:0]  id;
  } exp_t;

  exp_t        q[$];
  logic [31:0] rf[32];
  logic [31:0] last_res;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  // Reference arithmetic using native signed/unsigned 64-bit types
  function automatic logic [31:0] model(input fu_op op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    int              s;
    longint          sp;
    longint unsigned up;
    logic [63:0]     w;
    logic [7:0]      ab, bb;
    case (op)
      SMAQA: begin
        s = int'(c);
        for (int i = 0; i < 4; i++) begin
          ab = a[8*i +: 8];
          bb = b[8*i +: 8];
          s  = s + int'($signed(ab)) * int'($signed(bb));
        end
        return 32'(s);
      end
      MUL: begin
        up = longint'(a) * longint'(b);
        return up[31:0];
      end
      MULH: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        w  = sp;
        return w[63:32];
      end
      MULHSU: begin
        sp = longint'($signed(a)) * longint'({32'd0, b});
        w  = sp;
        return w[63:32];
      end
      MULHU: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        return up[63:32];
      end
      default: return 32'd0;
    endcase
  endfunction

  // Advance one edge and compare the DUT output stage against the scoreboard
  task automatic edge_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(mult_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".result"}, result_o, e.res);
      chk({tag, ".id"}, 32'(mult_trans_id_o), 32'(e.id));
      last_res = e.res;
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    we_i    = 1'b1;
    waddr_i = addr;
    wdata_i = data;
    edge_check("wr");
    we_i = 1'b0;
    if (addr != 5'd0) rf[addr] = data;
  endtask

  task automatic issue(input string tag, input logic [31:0] instr, input logic [2:0] id,
                       input fu_op op);
    logic [4:0] rs1, rs2, rd;
    exp_t       e;
    rs1 = instr[19:15];
    rs2 = instr[24:20];
    rd  = instr[11:7];
    @(negedge clk);
    instruction_i = instr;
    mult_valid_i  = 1'b1;
    trans_id_i    = id;
    #1;
    chk({tag, ".op"}, 32'(op_o), 32'(op));
    chk({tag, ".illegal"}, 32'(illegal_instr_o), 32'd0);
    chk({tag, ".opa"}, operand_a_o, rf[rs1]);
    chk({tag, ".opb"}, operand_b_o, rf[rs2]);
    chk({tag, ".opc"}, operand_c_o, rf[rd]);
    e.res = model(op, rf[rs1], rf[rs2], rf[rd]);
    e.id  = id;
    q.push_back(e);
    edge_check(tag);
    mult_valid_i = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    last_res      = '0;
    rst_n         = 1'b0;
    instruction_i = '0;
    mult_valid_i  = 1'b0;
    trans_id_i    = '0;
    waddr_i       = '0;
    wdata_i       = '0;
    we_i          = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    #12;
    chk("rst.valid", 32'(mult_valid_o), 32'd0);
    chk("rst.result", result_o, 32'd0);
    chk("rst.id", 32'(mult_trans_id_o), 32'd0);
    chk("rst.ready", 32'(mult_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic SMAQA
    wr(5'd1, 32'h01020304);
    wr(5'd2, 32'h05060708);
    wr(5'd3, 32'h00000009);
    issue("smaqa1", 32'hC82081F7, 3'd3, SMAQA);
    chk("smaqa1.lit", result_o, 32'h0000004F);

    // Most negative bytes times most positive bytes
    wr(5'd1, 32'h80808080);
    wr(5'd2, 32'h7F7F7F7F);
    wr(5'd3, 32'h00000000);
    issue("smaqa_neg", 32'hC82081F7, 3'd4, SMAQA);

    // Accumulator wrap
    wr(5'd1, 32'h01010101);
    wr(5'd2, 32'h01010101);
    wr(5'd3, 32'h7FFFFFFF);
    issue("smaqa_wrap", 32'hC82081F7, 3'd5, SMAQA);
    chk("smaqa_wrap.lit", result_o, 32'h80000003);

    // Multiply family, back to back
    wr(5'd1, 32'hFFFFFFFF);
    wr(5'd2, 32'h00000002);
    issue("mul", 32'h02208033, 3'd0, MUL);
    chk("mul.lit", result_o, 32'hFFFFFFFE);
    issue("mulh", 32'h02209033, 3'd1, MULH);
    chk("mulh.lit", result_o, 32'hFFFFFFFF);
    issue("mulhsu", 32'h0220A033, 3'd2, MULHSU);
    issue("mulhu", 32'h0220B033, 3'd3, MULHU);
    chk("mulhu.lit", result_o, 32'h00000001);

    // x0 ignores writes
    wr(5'd0, 32'h00001234);
    @(negedge clk);
    instruction_i = enc(7'h01, 5'd0, 5'd0, 3'd0, 5'd0, 7'h33);
    #1;
    chk("x0.read", operand_a_o, 32'd0);

    // Same-cycle write and read of x5
    wr(5'd5, 32'h0000AAAA);
    @(negedge clk);
    we_i          = 1'b1;
    waddr_i       = 5'd5;
    wdata_i       = 32'h00005555;
    instruction_i = enc(7'h01, 5'd0, 5'd5, 3'd0, 5'd0, 7'h33);
    #1;
    chk("x5.before", operand_a_o, 32'h0000AAAA);
    edge_check("x5");
    we_i  = 1'b0;
    rf[5] = 32'h00005555;
    chk("x5.after", operand_a_o, 32'h00005555);

    // Illegal instruction never issues and the result holds
    @(negedge clk);
    instruction_i = 32'hFFFFFFFF;
    mult_valid_i  = 1'b1;
    trans_id_i    = 3'd6;
    #1;
    chk("illegal.flag", 32'(illegal_instr_o), 32'd1);
    chk("illegal.op", 32'(op_o), 32'(ADD));
    edge_check("illegal");
    mult_valid_i = 1'b0;
    chk("illegal.hold", result_o, last_res);
    edge_check("idle");

    // Back-to-back trans_ids
    issue("b2b1", 32'h02208033, 3'd1, MUL);
    issue("b2b2", 32'h0220B033, 3'd2, MULHU);
    edge_check("b2b.idle");

    // Reset between issues drops the valid immediately
    issue("pre_rst", 32'h02208033, 3'd1, MUL);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(mult_valid_o), 32'd0);
    chk("midrst.result", result_o, 32'd0);
    chk("midrst.id", 32'(mult_trans_id_o), 32'd0);
    chk("midrst.ready", 32'(mult_ready_o), 32'd1);
    chk("midrst.rf", operand_a_o, 32'd0);
    q.delete();
    for (int i = 0; i < 32; i++) rf[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    edge_check("post_rst1");
    edge_check("post_rst2");
    wr(5'd1, 32'h00000007);
    wr(5'd2, 32'h00000006);
    issue("post_rst_issue", 32'h02208033, 3'd2, MUL);
    edge_check("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
